sparse_mode_switch_ctrl: RTL and testbench
==========================================

# sparse_mode_switch_ctrl

Controller that sequences sparsity-mode changes on the sparse MAC array. It sits between `sparsity_adaptive_fsm` (target mode source) and the tile-issue path / weight-decompressor configuration port. On a mode request it gates new tile issue and drains in-flight tiles. It then performs a config handshake with the decompressor, waits a settle interval, and resumes issue tagged with the new mode.

## Interface
Parameters:
- MAX_INFLIGHT, 16, max outstanding tiles; in-flight counter width = $clog2(MAX_INFLIGHT+1)
- SETTLE_CYCLES, 4, post-config idle cycles before issue resumes; 0 allowed
- DRAIN_TIMEOUT, 1024, DRAIN cycles before drain_timeout_err sets

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_mode  in  2  target mode (level): 0 DENSE, 1 2:4, 2 1:4, 3 1:8
- tile_in_valid  in  1  upstream tile offered
- tile_in_ready  out  1  upstream tile accepted
- tile_out_valid  out  1  tile to array
- tile_out_ready  in  1  array accepts tile
- tile_out_mode  out  2  mode tag for issued tile (= active_mode)
- tile_done  in  1  one-cycle pulse, one tile retired
- cfg_valid  out  1  decompressor config request
- cfg_mode  out  2  mode being configured
- cfg_ready  in  1  decompressor accepts config
- active_mode  out  2  committed mode
- busy  out  1  high whenever state != RUN
- inflight  out  cnt width  outstanding tiles
- switch_count  out  16  completed switches, wraps
- last_switch_cycles  out  16  cycles of last completed switch, saturates at 0xFFFF
- drain_timeout_err  out  1  sticky
- protocol_err  out  1  sticky, tile_done with inflight==0

## Operation
- Reset values: state RUN, active_mode 0, cfg_valid 0, cfg_mode 0, busy 0, inflight 0, switch_count 0, last_switch_cycles 0, both errs 0.
- gate = (state != RUN) or (req_mode != active_mode) or (inflight == MAX_INFLIGHT). Gate is combinational.
- Tile outputs: tile_out_valid = tile_in_valid & !gate; tile_in_ready = tile_out_ready & !gate. tile_out_mode = active_mode.
- inflight: +1 on issue (tile_out_valid & tile_out_ready), -1 on tile_done. Both in the same cycle leaves it unchanged. tile_done at 0 leaves it at 0 and sets protocol_err.
- State machine:
  - RUN: if req_mode != active_mode, latch target = req_mode, clear switch timer, go to DRAIN.
  - DRAIN: if req_mode == active_mode (request withdrawn), go to RUN with no reconfig and no count. Else if inflight == 0, re-latch target = req_mode and go to CONFIG. Drain counter reaching DRAIN_TIMEOUT sets drain_timeout_err; the block stays in DRAIN.
  - CONFIG: cfg_valid = 1 and cfg_mode = target, both held stable until cfg_ready. On handshake, active_mode <= target and switch_count++. Then go to SETTLE if SETTLE_CYCLES > 0, else RUN.
  - SETTLE: count SETTLE_CYCLES cycles, then go to RUN.
- On every DRAIN/CONFIG/SETTLE → RUN transition that followed a completed config, last_switch_cycles <= cycles spent outside RUN.
- A req_mode change during CONFIG or SETTLE is not applied mid-switch. On return to RUN, a mismatch starts a new switch immediately.
- Reset mid-switch: abort to RUN with DENSE; cfg_valid drops the next edge.

## Timing
- Issue gating takes effect in the same cycle that req_mode differs; no tile carries a stale mode after a request is visible.
- Minimum switch with empty pipe: 1 DRAIN + 1 CONFIG (cfg_ready already high) + SETTLE_CYCLES. That is 6 cycles with defaults; the first tile is issued in the following cycle.
- cfg_valid rises one cycle after the DRAIN exit condition.
- Error flags set one cycle after the triggering condition and stay set until reset.

## Structure
- Shared `sparsity_pkg`: mode encodings (MODE_DENSE..MODE_1TO8) shared with `sparsity_adaptive_fsm`, and the controller state enum.
- Sub-module `sparse_inflight_tracker`: up/down counter with full flag and underflow error.

## Test plan
- Idle switch: inflight 0, req_mode 0→2, cfg_ready = 1 → cfg_valid for 1 cycle with cfg_mode 2. Then active_mode = 2, switch_count = 1, last_switch_cycles = 6.
- Drain: 3 tiles issued, req_mode → 1 → tile_in_ready stays 0 and cfg_valid stays 0 until the 3rd tile_done; tiles issued afterwards are tagged 1.
- Withdrawn request: 2 tiles in flight, req_mode 0→3→0 within DRAIN → return to RUN, no cfg_valid, switch_count unchanged.
- cfg backpressure plus retarget: cfg_ready held low 5 cycles and req_mode changed 2→3 during CONFIG → cfg_mode stays 2. After settle, a second switch to 3 runs; switch_count = 2.
- Full and errors: issue 16 tiles without tile_done → tile_in_ready = 0. tile_done at inflight 0 → protocol_err = 1. No tile_done for 1024 DRAIN cycles → drain_timeout_err = 1.
- Reset during SETTLE → all outputs return to reset values, active_mode = 0.

Source files
------------

// File: rtl/sparsity_pkg.sv
// Shared sparsity definitions: mode encodings used by the adaptive FSM and
// this controller, plus the mode-switch controller state encoding.
package sparsity_pkg;

   typedef enum logic [1:0] {
      MODE_DENSE = 2'd0,
      MODE_2TO4  = 2'd1,
      MODE_1TO4  = 2'd2,
      MODE_1TO8  = 2'd3
   } sparsity_mode_e;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_CONFIG = 2'd2,
      ST_SETTLE = 2'd3
   } switch_state_e;

   // 16-bit increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/sparse_inflight_tracker.sv
// Up/down counter of tiles issued to the array but not yet retired.
// Flags full at MAX_INFLIGHT and latches an error on a retire at zero.
module sparse_inflight_tracker #(
   parameter int MAX_INFLIGHT = 16,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             underflow_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

   logic [CNT_W-1:0] count_reg, count_next;
   logic             err_reg, err_next;

   // Next count: simultaneous issue and retire cancel; retire at zero holds zero.
   always_comb begin
      count_next = count_reg;
      err_next   = err_reg;
      if (inc && !dec) begin
         count_next = count_reg + CNT_W'(1);
      end else if (dec && !inc && (count_reg != '0)) begin
         count_next = count_reg - CNT_W'(1);
      end
      if (dec && (count_reg == '0)) begin
         err_next = 1'b1;
      end
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   assign count         = count_reg;
   assign full          = (count_reg == CNT_MAX);
   assign underflow_err = err_reg;

endmodule

// File: rtl/sparse_mode_switch_ctrl.sv
// Sequences sparsity-mode changes: gates tile issue, drains the array,
// handshakes the new mode into the decompressor, settles, then resumes.
module sparse_mode_switch_ctrl
   import sparsity_pkg::*;
#(
   parameter int MAX_INFLIGHT  = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [1:0]                          req_mode,
   input  logic                                tile_in_valid,
   output logic                                tile_in_ready,
   output logic                                tile_out_valid,
   input  logic                                tile_out_ready,
   output logic [1:0]                          tile_out_mode,
   input  logic                                tile_done,
   output logic                                cfg_valid,
   output logic [1:0]                          cfg_mode,
   input  logic                                cfg_ready,
   output logic [1:0]                          active_mode,
   output logic                                busy,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
   output logic [15:0]                         switch_count,
   output logic [15:0]                         last_switch_cycles,
   output logic                                drain_timeout_err,
   output logic                                protocol_err
);

   localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);
   localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 2);
   localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);
   localparam logic [DRAIN_W-1:0]  DRAIN_MAX   = DRAIN_W'(DRAIN_TIMEOUT);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST =
      SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   switch_state_e       state_reg, state_next;
   logic [1:0]          target_reg, target_next;
   logic [1:0]          active_mode_reg, active_mode_next;
   logic [15:0]         switch_count_reg, switch_count_next;
   logic [15:0]         last_cycles_reg, last_cycles_next;
   logic [15:0]         timer_reg, timer_next;
   logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
   logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
   logic                timeout_err_reg, timeout_err_next;

   logic [CNT_W-1:0]    inflight_count;
   logic                inflight_full;
   logic                gate;
   logic                issue;

   // Issue is blocked the moment a different mode is requested, so no tile
   // ever leaves with a stale tag.
   assign gate = (state_reg != ST_RUN) || (req_mode != active_mode_reg) || inflight_full;
   assign tile_out_valid = tile_in_valid & ~gate;
   assign tile_in_ready  = tile_out_ready & ~gate;
   assign issue          = tile_out_valid & tile_out_ready;

   sparse_inflight_tracker #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
   ) u_tracker (
      .clk           (clk),
      .reset         (reset),
      .inc           (issue),
      .dec           (tile_done),
      .count         (inflight_count),
      .full          (inflight_full),
      .underflow_err (protocol_err)
   );

   // Next-state and switch bookkeeping; the timer counts every cycle spent
   // outside RUN, so the value stored on return includes the current cycle.
   always_comb begin
      state_next        = state_reg;
      target_next       = target_reg;
      active_mode_next  = active_mode_reg;
      switch_count_next = switch_count_reg;
      last_cycles_next  = last_cycles_reg;
      timer_next        = sat_inc16(timer_reg);
      drain_cnt_next    = drain_cnt_reg;
      settle_cnt_next   = settle_cnt_reg;
      timeout_err_next  = timeout_err_reg;
      cfg_valid         = 1'b0;
      case (state_reg)
         ST_RUN: begin
            timer_next = timer_reg;
            if (req_mode != active_mode_reg) begin
               target_next    = req_mode;
               timer_next     = '0;
               drain_cnt_next = '0;
               state_next     = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_reg != DRAIN_MAX) begin
               drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
            end
            if (drain_cnt_reg >= DRAIN_LAST) begin
               timeout_err_next = 1'b1;
            end
            if (req_mode == active_mode_reg) begin
               state_next = ST_RUN;
            end else if (inflight_count == '0) begin
               target_next = req_mode;
               state_next  = ST_CONFIG;
            end
         end
         ST_CONFIG: begin
            cfg_valid = 1'b1;
            if (cfg_ready) begin
               active_mode_next  = target_reg;
               switch_count_next = switch_count_reg + 16'd1;
               if (SETTLE_CYCLES > 0) begin
                  settle_cnt_next = '0;
                  state_next      = ST_SETTLE;
               end else begin
                  last_cycles_next = sat_inc16(timer_reg);
                  state_next       = ST_RUN;
               end
            end
         end
         ST_SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
               last_cycles_next = sat_inc16(timer_reg);
               state_next       = ST_RUN;
            end else begin
               settle_cnt_next = settle_cnt_reg + SETTLE_W'(1);
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   // Controller state registers; reset aborts any switch back to DENSE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_RUN;
         target_reg       <= MODE_DENSE;
         active_mode_reg  <= MODE_DENSE;
         switch_count_reg <= '0;
         last_cycles_reg  <= '0;
         timer_reg        <= '0;
         drain_cnt_reg    <= '0;
         settle_cnt_reg   <= '0;
         timeout_err_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         target_reg       <= target_next;
         active_mode_reg  <= active_mode_next;
         switch_count_reg <= switch_count_next;
         last_cycles_reg  <= last_cycles_next;
         timer_reg        <= timer_next;
         drain_cnt_reg    <= drain_cnt_next;
         settle_cnt_reg   <= settle_cnt_next;
         timeout_err_reg  <= timeout_err_next;
      end
   end

   assign cfg_mode           = target_reg;
   assign active_mode        = active_mode_reg;
   assign tile_out_mode      = active_mode_reg;
   assign busy               = (state_reg != ST_RUN);
   assign inflight           = inflight_count;
   assign switch_count       = switch_count_reg;
   assign last_switch_cycles = last_cycles_reg;
   assign drain_timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_sparse_mode_switch_ctrl.sv
// Directed bench for sparse_mode_switch_ctrl with hand-computed expectations.
module tb_sparse_mode_switch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_mode;
   logic        tile_in_valid;
   logic        tile_in_ready;
   logic        tile_out_valid;
   logic        tile_out_ready;
   logic [1:0]  tile_out_mode;
   logic        tile_done;
   logic        cfg_valid;
   logic [1:0]  cfg_mode;
   logic        cfg_ready;
   logic [1:0]  active_mode;
   logic        busy;
   logic [4:0]  inflight;
   logic [15:0] switch_count;
   logic [15:0] last_switch_cycles;
   logic        drain_timeout_err;
   logic        protocol_err;

   int total = 0;
   int bad   = 0;

   sparse_mode_switch_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .req_mode           (req_mode),
      .tile_in_valid      (tile_in_valid),
      .tile_in_ready      (tile_in_ready),
      .tile_out_valid     (tile_out_valid),
      .tile_out_ready     (tile_out_ready),
      .tile_out_mode      (tile_out_mode),
      .tile_done          (tile_done),
      .cfg_valid          (cfg_valid),
      .cfg_mode           (cfg_mode),
      .cfg_ready          (cfg_ready),
      .active_mode        (active_mode),
      .busy               (busy),
      .inflight           (inflight),
      .switch_count       (switch_count),
      .last_switch_cycles (last_switch_cycles),
      .drain_timeout_err  (drain_timeout_err),
      .protocol_err       (protocol_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_reset_values(input string pfx);
      chk({pfx, "_active"},   {30'd0, active_mode}, 32'd0);
      chk({pfx, "_busy"},     {31'd0, busy}, 32'd0);
      chk({pfx, "_cfgv"},     {31'd0, cfg_valid}, 32'd0);
      chk({pfx, "_cfgm"},     {30'd0, cfg_mode}, 32'd0);
      chk({pfx, "_inflight"}, {27'd0, inflight}, 32'd0);
      chk({pfx, "_swcnt"},    {16'd0, switch_count}, 32'd0);
      chk({pfx, "_last"},     {16'd0, last_switch_cycles}, 32'd0);
      chk({pfx, "_dterr"},    {31'd0, drain_timeout_err}, 32'd0);
      chk({pfx, "_perr"},     {31'd0, protocol_err}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int cv;
      int cm;
      int viol;

      reset          = 1'b1;
      req_mode       = 2'd0;
      tile_in_valid  = 1'b0;
      tile_out_ready = 1'b1;
      tile_done      = 1'b0;
      cfg_ready      = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk_reset_values("rst");

      // Idle switch 0 -> 2: 1 DRAIN + 1 CONFIG + 4 SETTLE
      req_mode = 2'd2;
      #1;
      chk("idle_gate_ready", {31'd0, tile_in_ready}, 32'd0);
      n = 0; cv = 0; cm = 0;
      tick();
      while (busy && n < 40) begin
         n++;
         if (cfg_valid) begin
            cv++;
            cm = int'(cfg_mode);
         end
         tick();
      end
      chk("idle_busy_cycles", n, 6);
      chk("idle_cfgv_cycles", cv, 1);
      chk("idle_cfg_mode", cm, 2);
      chk("idle_active", {30'd0, active_mode}, 32'd2);
      chk("idle_swcnt", {16'd0, switch_count}, 32'd1);
      chk("idle_last", {16'd0, last_switch_cycles}, 32'd6);

      // Drain: three tiles in flight, switch to 1
      chk("drain_ready_pre", {31'd0, tile_in_ready}, 32'd1);
      tile_in_valid = 1'b1;
      chk("drain_tag_pre", {30'd0, tile_out_mode}, 32'd2);
      tick(); tick(); tick();
      tile_in_valid = 1'b0;
      chk("drain_inflight3", {27'd0, inflight}, 32'd3);
      req_mode = 2'd1;
      tile_in_valid = 1'b1;
      #1;
      chk("drain_gate_ready", {31'd0, tile_in_ready}, 32'd0);
      chk("drain_gate_valid", {31'd0, tile_out_valid}, 32'd0);
      viol = 0;
      repeat (4) begin
         tick();
         if (tile_in_ready || tile_out_valid || cfg_valid) viol++;
      end
      pulse_done();
      if (tile_in_ready || cfg_valid) viol++;
      pulse_done();
      if (tile_in_ready || cfg_valid) viol++;
      pulse_done();
      if (tile_in_ready || cfg_valid) viol++;
      chk("drain_gated_viol", viol, 0);
      chk("drain_inflight0", {27'd0, inflight}, 32'd0);
      wait_idle("drain_idle", 40);
      chk("drain_new_valid", {31'd0, tile_out_valid}, 32'd1);
      chk("drain_new_tag", {30'd0, tile_out_mode}, 32'd1);
      chk("drain_swcnt", {16'd0, switch_count}, 32'd2);
      chk("drain_last", {16'd0, last_switch_cycles}, 32'd12);
      tick();
      tile_in_valid = 1'b0;
      chk("drain_post_issue", {27'd0, inflight}, 32'd1);
      pulse_done();
      chk("drain_post_retire", {27'd0, inflight}, 32'd0);

      // Withdrawn request with two tiles in flight
      tile_in_valid = 1'b1;
      tick(); tick();
      tile_in_valid = 1'b0;
      chk("wd_inflight2", {27'd0, inflight}, 32'd2);
      req_mode = 2'd3;
      viol = 0;
      tick();
      if (cfg_valid) viol++;
      chk("wd_busy_drain", {31'd0, busy}, 32'd1);
      tick();
      if (cfg_valid) viol++;
      req_mode = 2'd1;
      tick();
      chk("wd_back_run", {31'd0, busy}, 32'd0);
      repeat (3) begin
         tick();
         if (cfg_valid || busy) viol++;
      end
      chk("wd_no_cfg", viol, 0);
      chk("wd_swcnt", {16'd0, switch_count}, 32'd2);
      chk("wd_last", {16'd0, last_switch_cycles}, 32'd12);
      chk("wd_active", {30'd0, active_mode}, 32'd1);
      pulse_done();
      pulse_done();
      chk("wd_inflight0", {27'd0, inflight}, 32'd0);

      // Config backpressure with retarget during CONFIG
      cfg_ready = 1'b0;
      req_mode  = 2'd2;
      tick();
      tick();
      chk("bp_cfgv", {31'd0, cfg_valid}, 32'd1);
      chk("bp_cfgm", {30'd0, cfg_mode}, 32'd2);
      req_mode = 2'd3;
      viol = 0;
      repeat (4) begin
         tick();
         if (!cfg_valid || cfg_mode != 2'd2) viol++;
      end
      chk("bp_cfg_stable", viol, 0);
      cfg_ready = 1'b1;
      tick();
      chk("bp_active2", {30'd0, active_mode}, 32'd2);
      chk("bp_swcnt3", {16'd0, switch_count}, 32'd3);
      wait_idle("bp_idle1", 20);
      chk("bp_last10", {16'd0, last_switch_cycles}, 32'd10);
      chk("bp_run_gated", {31'd0, tile_in_ready}, 32'd0);
      tick();
      chk("bp_restart", {31'd0, busy}, 32'd1);
      wait_idle("bp_idle2", 20);
      chk("bp_active3", {30'd0, active_mode}, 32'd3);
      chk("bp_swcnt4", {16'd0, switch_count}, 32'd4);
      chk("bp_last6", {16'd0, last_switch_cycles}, 32'd6);

      // Full: 16 tiles with no retire
      tile_in_valid = 1'b1;
      repeat (16) tick();
      chk("full_inflight", {27'd0, inflight}, 32'd16);
      chk("full_ready", {31'd0, tile_in_ready}, 32'd0);
      chk("full_valid", {31'd0, tile_out_valid}, 32'd0);
      tick();
      chk("full_hold", {27'd0, inflight}, 32'd16);
      tile_in_valid = 1'b0;
      repeat (16) pulse_done();
      chk("full_empty", {27'd0, inflight}, 32'd0);
      chk("perr_pre", {31'd0, protocol_err}, 32'd0);
      pulse_done();
      chk("perr_set", {31'd0, protocol_err}, 32'd1);
      chk("perr_inflight", {27'd0, inflight}, 32'd0);

      // Drain timeout: one tile never retires
      tile_in_valid = 1'b1;
      tick();
      tile_in_valid = 1'b0;
      req_mode = 2'd0;
      repeat (1000) tick();
      chk("to_busy", {31'd0, busy}, 32'd1);
      chk("to_pre", {31'd0, drain_timeout_err}, 32'd0);
      repeat (40) tick();
      chk("to_set", {31'd0, drain_timeout_err}, 32'd1);
      chk("to_still_drain", {31'd0, busy}, 32'd1);
      chk("perr_sticky", {31'd0, protocol_err}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_reset_values("rst2");

      // Reset during SETTLE
      req_mode = 2'd2;
      tick(); tick(); tick();
      chk("rs_busy", {31'd0, busy}, 32'd1);
      chk("rs_active", {30'd0, active_mode}, 32'd2);
      reset = 1'b1;
      req_mode = 2'd0;
      tick();
      reset = 1'b0;
      chk_reset_values("rst3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
